alu_unit: RTL and testbench
===========================

# alu_unit

Combinational 16-bit ALU core with operand forwarding and a small registered flag file, instantiated inside the execute stage (`ALU_stage`) of the 5-stage pipelined processor. It selects each operand from the register file or from one of the in-flight results (previous ALU result, two-back ALU result, or load data). It executes one of 16 operations and presents the result and carry/zero/negative flags combinationally. The flag register is held across operations that do not affect flags.

## Interface
Parameters: none (data width fixed at 16, register index width fixed at 3).

- clk  in  1  pipeline clock; flag register updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- register_content1  in  16  source operand A from register file (Rsrc)
- register_content2  in  16  operand B from register file (Rdst)
- alu_control_signal  in  4  operation code
- out  out  16  result (combinational)
- carry, zero, neg  out  1 each  flag values after the current operation (combinational)
- instruction  in  16  immediate word; [3:0] is the shift amount
- wb1, wb2  in  1 each  instruction 1 back / 2 back writes a register
- mem_write1, mem_write2  in  1 each  instruction 1 back / 2 back is a store
- result_buf, result_buf2  in  16 each  ALU result 1 back / 2 back
- reg1_buf1, reg2_buf1  in  3 each  current operand A / operand B register index
- reg2_buf2, reg2_buf3  in  3 each  destination index of instruction 1 back / 2 back
- memory_data_output_load_case  in  16  load data of the instruction 2 back
- mem_read  in  1  instruction 1 back is a load (its result is not yet valid)
- mem_read_load_case  in  1  instruction 2 back is a load

## Operation
- Forwarding is evaluated independently for A (index reg1_buf1) and B (index reg2_buf1). The first matching rule applies:
  1. If wb1 & !mem_write1 & !mem_read & reg2_buf2==idx, the operand is result_buf.
  2. Else if wb2 & !mem_write2 & reg2_buf3==idx, the operand is memory_data_output_load_case when mem_read_load_case is set, otherwise result_buf2.
  3. Otherwise the operand is register_content1 or register_content2.
- Opcodes. "Held" means the flag keeps its registered value. All arithmetic is modulo 2^16.
  - 0 NOP: out=A; all flags held.
  - 1 SETC: out=B; C=1; Z and N held.
  - 2 CLRC: out=B; C=0; Z and N held.
  - 3 NOT: out=~B; Z and N updated; C held.
  - 4 INC: out=B+1; C is the carry out.
  - 5 DEC: out=B-1; C is the borrow.
  - 6 MOV: out=A; all flags held.
  - 7 ADD: out=A+B; C is the carry out of bit 15.
  - 8 SUB: out=B-A; C=1 when A>B (borrow).
  - 9 AND, 10 OR: out=B&A or B|A; Z and N updated; C held.
  - 11 SHL: out=B<<instruction[3:0]; C is the last bit shifted out.
  - 12 SHR: out=B>>instruction[3:0], logical shift; C is the last bit shifted out.
  - For SHL/SHR with a shift amount of 0: out=B and C is held.
  - 13 IADD: out=B+instruction; C is the carry out.
  - 14 LDM: out=instruction; all flags held.
  - 15 PASS: out=B, used for store/push data; all flags held.
- Wherever Z and N are updated: Z = (out==0) and N = out[15]. Ops 4, 5, 7, 8, 11, 12 and 13 update C, Z and N.
- The carry/zero/neg outputs always equal the next flag values: updated values for affected flags, registered values for held flags.

## Timing
- out and the flag outputs are purely combinational from the inputs and the flag register, with zero latency.
- The flag register {C,Z,N} loads the next flag values on each rising edge of clk.
- rst_n low clears the flag register to 000 immediately (asynchronous), independent of clk. While reset is held, held flags read 0.
- Release of rst_n takes effect on the next rising edge.
- When rule 1 and rule 2 both match the same index, rule 1 wins because it carries the newest value.
- When both operands match the same source, both are forwarded.
- With mem_read set, the 1-back result is never forwarded; stalling is the hazard unit's responsibility.

## Test plan
- Reset: drive rst_n=0 mid-cycle, then set op=0 → carry=zero=neg=0 immediately. Release, apply op=1 and a clock edge, then op=0 → carry=1.
- ADD overflow: A=0xFFFF, B=0x0001, op=7, no forwarding → out=0x0000, carry=1, zero=1, neg=0.
- SUB borrow: A=5, B=3, op=8 → out=0xFFFE, carry=1, neg=1, zero=0.
- Forward priority: reg1_buf1=2, reg2_buf2=2, reg2_buf3=2, wb1=wb2=1, result_buf=0x1111, result_buf2=0x2222, op=6 → out=0x1111. Then set mem_read=1 → out=0x2222. Then set mem_read_load_case=1 with load data 0x3333 → out=0x3333.
- Store suppression: wb1=1, mem_write1=1, indices match, register_content2=0x00AA, op=15 → out=0x00AA.
- Flag hold: ADD producing C=1 then a clock edge, then AND 0x0F0F&0xF0F0 → out=0, zero=1, carry stays 1. Then SHL by 0 → out=B, carry still 1.

Source files
------------

// File: rtl/alu_unit.sv
// 16-bit execute-stage ALU: operand forwarding, 16 operations, and a registered
// {carry, zero, neg} flag file whose held bits feed straight back to the outputs.
module alu_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] register_content1,
   input  logic [15:0] register_content2,
   input  logic [3:0]  alu_control_signal,
   output logic [15:0] out,
   output logic        carry,
   output logic        zero,
   output logic        neg,
   input  logic [15:0] instruction,
   input  logic        wb1,
   input  logic        wb2,
   input  logic        mem_write1,
   input  logic        mem_write2,
   input  logic [15:0] result_buf,
   input  logic [15:0] result_buf2,
   input  logic [2:0]  reg1_buf1,
   input  logic [2:0]  reg2_buf1,
   input  logic [2:0]  reg2_buf2,
   input  logic [2:0]  reg2_buf3,
   input  logic [15:0] memory_data_output_load_case,
   input  logic        mem_read,
   input  logic        mem_read_load_case
);

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,  OP_SETC = 4'd1,  OP_CLRC = 4'd2,  OP_NOT  = 4'd3,
      OP_INC  = 4'd4,  OP_DEC  = 4'd5,  OP_MOV  = 4'd6,  OP_ADD  = 4'd7,
      OP_SUB  = 4'd8,  OP_AND  = 4'd9,  OP_OR   = 4'd10, OP_SHL  = 4'd11,
      OP_SHR  = 4'd12, OP_IADD = 4'd13, OP_LDM  = 4'd14, OP_PASS = 4'd15
   } op_e;

   typedef struct packed {
      logic c;
      logic z;
      logic n;
   } flags_t;

   flags_t      flag_q;
   flags_t      flag_d;
   logic [15:0] opa;
   logic [15:0] opb;
   logic        upd_zn;
   logic        fwd1_ok;
   logic        fwd2_ok;
   logic [15:0] fwd2_data;
   logic [3:0]  shamt;
   logic [16:0] shl_ext;
   logic [16:0] shr_ext;

   // A load one back has no result yet, so it is never a forwarding source.
   assign fwd1_ok   = wb1 & ~mem_write1 & ~mem_read;
   assign fwd2_ok   = wb2 & ~mem_write2;
   assign fwd2_data = mem_read_load_case ? memory_data_output_load_case : result_buf2;

   // NOTE: every combinational output gets a default before any branch so no latch is inferred.
   always_comb begin
      opa = register_content1;
      if (fwd1_ok && (reg2_buf2 == reg1_buf1))
         opa = result_buf;
      else if (fwd2_ok && (reg2_buf3 == reg1_buf1))
         opa = fwd2_data;
   end

   always_comb begin
      opb = register_content2;
      if (fwd1_ok && (reg2_buf2 == reg2_buf1))
         opb = result_buf;
      else if (fwd2_ok && (reg2_buf3 == reg2_buf1))
         opb = fwd2_data;
   end

   // Extra bit catches the last bit shifted out in either direction.
   assign shamt   = instruction[3:0];
   assign shl_ext = {1'b0, opb} << shamt;
   assign shr_ext = {opb, 1'b0} >> shamt;

   always_comb begin
      out    = opb;
      flag_d = flag_q;
      upd_zn = 1'b0;
      case (op_e'(alu_control_signal))
         OP_NOP, OP_MOV: out = opa;
         OP_SETC:        flag_d.c = 1'b1;
         OP_CLRC:        flag_d.c = 1'b0;
         OP_NOT:  begin out = ~opb; upd_zn = 1'b1; end
         OP_INC:  begin {flag_d.c, out} = {1'b0, opb} + 17'd1; upd_zn = 1'b1; end
         OP_DEC:  begin {flag_d.c, out} = {1'b0, opb} - 17'd1; upd_zn = 1'b1; end
         OP_ADD:  begin {flag_d.c, out} = {1'b0, opa} + {1'b0, opb}; upd_zn = 1'b1; end
         OP_SUB:  begin {flag_d.c, out} = {1'b0, opb} - {1'b0, opa}; upd_zn = 1'b1; end
         OP_AND:  begin out = opb & opa; upd_zn = 1'b1; end
         OP_OR:   begin out = opb | opa; upd_zn = 1'b1; end
         OP_SHL: begin
            out    = shl_ext[15:0];
            upd_zn = 1'b1;
            if (shamt != 4'd0) flag_d.c = shl_ext[16];
         end
         OP_SHR: begin
            out    = shr_ext[16:1];
            upd_zn = 1'b1;
            if (shamt != 4'd0) flag_d.c = shr_ext[0];
         end
         OP_IADD: begin {flag_d.c, out} = {1'b0, opb} + {1'b0, instruction}; upd_zn = 1'b1; end
         OP_LDM:         out = instruction;
         OP_PASS:        out = opb;
      endcase
      if (upd_zn) begin
         flag_d.z = (out == 16'd0);
         flag_d.n = out[15];
      end
   end

   assign carry = flag_d.c;
   assign zero  = flag_d.z;
   assign neg   = flag_d.n;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         flag_q <= '0;
      else
         flag_q <= flag_d;
   end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: a spec-level arithmetic model compared every negedge,
// plus directed vectors with hand-computed literal results.
module tb_alu_unit;

   bit          clk;
   logic        rst_n;
   logic [15:0] register_content1, register_content2, instruction;
   logic [3:0]  alu_control_signal;
   logic [15:0] out;
   logic        carry, zero, neg;
   logic        wb1, wb2, mem_write1, mem_write2, mem_read, mem_read_load_case;
   logic [15:0] result_buf, result_buf2, memory_data_output_load_case;
   logic [2:0]  reg1_buf1, reg2_buf1, reg2_buf2, reg2_buf3;

   int n_cmp = 0;
   int n_bad = 0;
   logic [2:0] mflags;

   alu_unit dut (
      .clk(clk), .rst_n(rst_n),
      .register_content1(register_content1), .register_content2(register_content2),
      .alu_control_signal(alu_control_signal), .out(out),
      .carry(carry), .zero(zero), .neg(neg), .instruction(instruction),
      .wb1(wb1), .wb2(wb2), .mem_write1(mem_write1), .mem_write2(mem_write2),
      .result_buf(result_buf), .result_buf2(result_buf2),
      .reg1_buf1(reg1_buf1), .reg2_buf1(reg2_buf1),
      .reg2_buf2(reg2_buf2), .reg2_buf3(reg2_buf3),
      .memory_data_output_load_case(memory_data_output_load_case),
      .mem_read(mem_read), .mem_read_load_case(mem_read_load_case)
   );

   initial forever #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int fwd(input logic [2:0] idx, input logic [15:0] rf);
      if (wb1 && !mem_write1 && !mem_read && reg2_buf2 == idx) return int'(result_buf);
      if (wb2 && !mem_write2 && reg2_buf3 == idx)
         return mem_read_load_case ? int'(memory_data_output_load_case) : int'(result_buf2);
      return int'(rf);
   endfunction

   // Flags are {C,Z,N}; f is the current flag register.
   function automatic void model(input logic [2:0] f, output logic [15:0] o, output logic [2:0] nf);
      int a, b, r, sh;
      logic c, z, n, zn;
      a  = fwd(reg1_buf1, register_content1);
      b  = fwd(reg2_buf1, register_content2);
      sh = int'(instruction[3:0]);
      {c, z, n} = f;
      zn = 1'b0;
      r  = b;
      case (alu_control_signal)
         4'd0, 4'd6: r = a;
         4'd1: c = 1'b1;
         4'd2: c = 1'b0;
         4'd3: begin r = (~b) & 'hFFFF; zn = 1'b1; end
         4'd4: begin r = b + 1; c = (r > 'hFFFF); zn = 1'b1; end
         4'd5: begin c = (b == 0); r = (b + 'hFFFF) & 'hFFFF; zn = 1'b1; end
         4'd7: begin r = a + b; c = (r > 'hFFFF); zn = 1'b1; end
         4'd8: begin c = (a > b); r = (b - a + 'h10000) & 'hFFFF; zn = 1'b1; end
         4'd9: begin r = a & b; zn = 1'b1; end
         4'd10: begin r = a | b; zn = 1'b1; end
         4'd11: begin
            r = (b << sh) & 'hFFFF; zn = 1'b1;
            if (sh != 0) c = (((b >> (16 - sh)) & 1) != 0);
         end
         4'd12: begin
            r = b >> sh; zn = 1'b1;
            if (sh != 0) c = (((b >> (sh - 1)) & 1) != 0);
         end
         4'd13: begin r = b + int'(instruction); c = (r > 'hFFFF); zn = 1'b1; end
         4'd14: r = int'(instruction);
         default: r = b;
      endcase
      o = r[15:0];
      if (zn) begin
         z = (o == 16'd0);
         n = o[15];
      end
      nf = {c, z, n};
   endfunction

   function automatic logic [2:0] model_next(input logic [2:0] f);
      logic [15:0] o;
      logic [2:0]  nf;
      model(f, o, nf);
      return nf;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mflags <= 3'b000;
      else        mflags <= model_next(mflags);
   end

   always @(negedge clk) begin
      logic [15:0] mo;
      logic [2:0]  mf;
      model(mflags, mo, mf);
      check("model_out", out, mo);
      check("model_flags", {13'd0, carry, zero, neg}, {13'd0, mf});
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] ins);
      alu_control_signal = op;
      register_content1  = a;
      register_content2  = b;
      instruction        = ins;
      #1;
   endtask

   task automatic clear_fwd();
      {wb1, wb2, mem_write1, mem_write2, mem_read, mem_read_load_case} = '0;
      result_buf = 16'h0; result_buf2 = 16'h0; memory_data_output_load_case = 16'h0;
      reg1_buf1 = 3'd0; reg2_buf1 = 3'd1; reg2_buf2 = 3'd6; reg2_buf3 = 3'd7;
   endtask

   typedef struct {
      logic [3:0]  op;
      logic [15:0] b;
      logic [15:0] ins;
      logic [15:0] exp_out;
      logic        chk_c;
      logic        exp_c;
   } vec_t;

   vec_t vecs[10] = '{
      '{4'd11, 16'h8001, 16'h0001, 16'h0002, 1'b1, 1'b1},
      '{4'd12, 16'h00F8, 16'h0004, 16'h000F, 1'b1, 1'b1},
      '{4'd4,  16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1},
      '{4'd5,  16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b1},
      '{4'd13, 16'h1234, 16'h1000, 16'h2234, 1'b1, 1'b0},
      '{4'd3,  16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0},
      '{4'd14, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b0},
      '{4'd10, 16'h00F0, 16'h0000, 16'h0FF0, 1'b0, 1'b0},
      '{4'd2,  16'h0007, 16'h0000, 16'h0007, 1'b1, 1'b0},
      '{4'd12, 16'h8000, 16'h000F, 16'h0001, 1'b1, 1'b0}
   };

   initial begin
      rst_n = 1'b0;
      clear_fwd();
      apply(4'd0, 16'h0, 16'h0, 16'h0);
      check("reset_flags", {13'd0, carry, zero, neg}, 16'h0000);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // ADD overflow
      tick();
      apply(4'd7, 16'hFFFF, 16'h0001, 16'h0);
      check("add_ovf_out", out, 16'h0000);
      check("add_ovf_flags", {13'd0, carry, zero, neg}, 16'h0006);

      // Asynchronous reset mid-cycle, then SETC after release
      tick();
      rst_n = 1'b0;
      apply(4'd0, 16'h0, 16'h0, 16'h0);
      check("async_rst_flags", {13'd0, carry, zero, neg}, 16'h0000);
      rst_n = 1'b1;
      apply(4'd1, 16'h0, 16'h0, 16'h0);
      tick();
      apply(4'd0, 16'h0, 16'h0, 16'h0);
      check("setc_held_flags", {13'd0, carry, zero, neg}, 16'h0004);

      // SUB borrow
      tick();
      apply(4'd8, 16'h0005, 16'h0003, 16'h0);
      check("sub_out", out, 16'hFFFE);
      check("sub_flags", {13'd0, carry, zero, neg}, 16'h0005);

      // Forwarding priority
      tick();
      reg1_buf1 = 3'd2; reg2_buf2 = 3'd2; reg2_buf3 = 3'd2;
      wb1 = 1'b1; wb2 = 1'b1;
      result_buf = 16'h1111; result_buf2 = 16'h2222;
      apply(4'd6, 16'h0005, 16'h0009, 16'h0);
      check("fwd_1back", out, 16'h1111);
      mem_read = 1'b1;
      #1 check("fwd_2back", out, 16'h2222);
      mem_read_load_case = 1'b1; memory_data_output_load_case = 16'h3333;
      #1 check("fwd_load", out, 16'h3333);
      reg2_buf1 = 3'd2;
      apply(4'd15, 16'h0005, 16'h0009, 16'h0);
      check("fwd_opb_same_src", out, 16'h3333);
      tick();
      clear_fwd();

      // Store suppression on the 1-back slot
      reg2_buf1 = 3'd4; reg2_buf2 = 3'd4;
      wb1 = 1'b1; mem_write1 = 1'b1; result_buf = 16'hBEEF;
      apply(4'd15, 16'h0000, 16'h00AA, 16'h0);
      check("store_suppress", out, 16'h00AA);
      tick();
      clear_fwd();

      // Flag hold across logical ops and zero-length shift
      apply(4'd7, 16'hFFFF, 16'h0001, 16'h0);
      tick();
      apply(4'd9, 16'h0F0F, 16'hF0F0, 16'h0);
      check("and_out", out, 16'h0000);
      check("and_flags", {13'd0, carry, zero, neg}, 16'h0006);
      tick();
      apply(4'd11, 16'h0000, 16'h8001, 16'h0000);
      check("shl0_out", out, 16'h8001);
      check("shl0_flags", {13'd0, carry, zero, neg}, 16'h0005);

      for (int i = 0; i < 10; i++) begin
         tick();
         apply(vecs[i].op, 16'h0F00, vecs[i].b, vecs[i].ins);
         check($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
         if (vecs[i].chk_c)
            check($sformatf("vec%0d_carry", i), {15'd0, carry}, {15'd0, vecs[i].exp_c});
      end

      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
